// File: rtl/fixp_mac_sequencer.sv
// Dot-product sequencer around an external pipelined signed multiplier.
// Issues len operand pairs, accumulates products at full precision, emits one rescaled, saturated result.
module fixp_mac_sequencer #(
   parameter int WIDTH       = 32,
   parameter int POINT_WIDTH = 16,
   parameter int MUL_LATENCY = 4,
   parameter int LEN_WIDTH   = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [LEN_WIDTH-1:0]   len,
   output logic                   busy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_a,
   input  logic [WIDTH-1:0]       in_b,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   input  logic [2*WIDTH-1:0]     mul_p,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_sat
);

   localparam int ACC_W = 2*WIDTH + LEN_WIDTH;

   localparam logic signed [ACC_W-1:0] C_MAX =
      {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] C_MIN =
      {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [LEN_WIDTH-1:0]      r_len;
   logic [LEN_WIDTH-1:0]      r_cnt;
   logic [MUL_LATENCY-1:0]    r_vpipe;
   logic [MUL_LATENCY-1:0]    w_vpipe_next;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [ACC_W-1:0]   w_p_ext;
   logic signed [ACC_W-1:0]   w_shift;
   logic [WIDTH-1:0]          w_res;
   logic                      w_sat;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_start_cmd;
   logic                      w_drained;

   assign in_ready    = (r_state == S_ISSUE) && (r_cnt < r_len);
   assign w_accept    = in_valid && in_ready;
   assign w_last      = (r_cnt + LEN_WIDTH'(1)) == r_len;
   assign w_start_cmd = (r_state == S_IDLE) && start;
   assign w_drained   = (r_state == S_DRAIN) && (r_vpipe == '0);
   assign busy        = (r_state != S_IDLE);
   assign out_valid   = (r_state == S_DONE);

   assign w_p_ext = {{LEN_WIDTH{mul_p[2*WIDTH-1]}}, mul_p};
   assign w_shift = r_acc >>> POINT_WIDTH;

   // The valid pipeline mirrors the multiplier depth so bubbles stay aligned with products.
   always_comb begin
      w_vpipe_next    = r_vpipe << 1;
      w_vpipe_next[0] = w_accept;
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
      w_res = w_shift[WIDTH-1:0];
      w_sat = 1'b0;
      if (w_shift > C_MAX) begin
         w_res = C_MAX[WIDTH-1:0];
         w_sat = 1'b1;
      end else if (w_shift < C_MIN) begin
         w_res = C_MIN[WIDTH-1:0];
         w_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = (len == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            if (w_accept && w_last) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_vpipe == '0) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the valid pipeline is reset so in-flight products are discarded on reset.
      if (!rst_n) begin
         r_len    <= '0;
         r_cnt    <= '0;
         r_vpipe  <= '0;
         r_acc    <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         out_data <= '0;
         out_sat  <= 1'b0;
      end else begin
         r_vpipe <= w_vpipe_next;

         if (w_start_cmd) begin
            r_len <= len;
            r_cnt <= '0;
            r_acc <= '0;
         end else if (r_vpipe[MUL_LATENCY-1]) begin
            r_acc <= r_acc + w_p_ext;
         end

         if (w_accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
            r_cnt <= r_cnt + LEN_WIDTH'(1);
         end

         // Result registers only move on the edge that raises out_valid.
         if (w_start_cmd && (len == '0)) begin
            out_data <= '0;
            out_sat  <= 1'b0;
         end else if (w_drained) begin
            out_data <= w_res;
            out_sat  <= w_sat;
         end
      end
   end

endmodule

// File: tb/tb_fixp_mac_sequencer.sv
// Directed bench for fixp_mac_sequencer with a behavioural pipelined multiplier.
module tb_fixp_mac_sequencer;

   localparam int W  = 32;
   localparam int PW = 16;
   localparam int L  = 4;
   localparam int LW = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LW-1:0]     len = '0;
   logic              busy;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      in_a = '0;
   logic [W-1:0]      in_b = '0;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic [2*W-1:0]    mul_p;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic              out_sat;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] va [8];
   logic [W-1:0] vb [8];
   bit           vpat [$];
   bit           poke = 1'b0;

   fixp_mac_sequencer #(
      .WIDTH       (W),
      .POINT_WIDTH (PW),
      .MUL_LATENCY (L),
      .LEN_WIDTH   (LW)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   // Multiplier model: product valid L edges after the operands were registered.
   logic signed [2*W-1:0] ea, eb;
   logic [2*W-1:0]        mp [L-1];
   assign ea = {{W{mul_a[W-1]}}, mul_a};
   assign eb = {{W{mul_b[W-1]}}, mul_b};
   assign mul_p = mp[L-2];

   always @(posedge clk) begin
      mp[0] <= ea * eb;
      for (int i = 1; i < L-1; i++) mp[i] <= mp[i-1];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_pairs(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < n; i++) begin
         va[i] = a;
         vb[i] = b;
      end
   endtask

   task automatic run_cmd(input int n, input logic [W-1:0] exp_d, input logic exp_s,
                          input string tag);
      int  c;
      int  acc;
      int  last;
      int  pi;
      bit  took;
      c = 0; acc = 0; last = 0; pi = 0;
      @(negedge clk);
      start = 1'b1;
      len   = LW'(n);
      @(negedge clk);
      c = 1;
      start = 1'b0;
      len   = '0;
      if (n == 0) begin
         check({tag, "_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_data"}, 64'(out_data), 64'(exp_d));
         check({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
      end else begin
         check({tag, "_busy"}, 64'(busy), 64'd1);
         check({tag, "_ready"}, 64'(in_ready), 64'd1);
         while (acc < n && c < 200) begin
            in_valid = (pi < vpat.size()) ? vpat[pi] : 1'b1;
            pi++;
            in_a  = va[acc];
            in_b  = vb[acc];
            start = poke && (c == 3);
            len   = (poke && (c == 3)) ? LW'(7) : '0;
            took  = in_valid && in_ready;
            if (took) begin
               acc++;
               last = c;
            end
            @(negedge clk);
            c++;
            if (took) check({tag, "_mul_a"}, 64'(mul_a), 64'(va[acc-1]));
         end
         in_valid = 1'b0;
         start    = 1'b0;
         len      = '0;
         check({tag, "_accepts"}, 64'(acc), 64'(n));
         check({tag, "_ready_drop"}, 64'(in_ready), 64'd0);
         while (!out_valid && c < last + 50) begin
            @(negedge clk);
            c++;
         end
         check({tag, "_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_latency"}, 64'(c - last), 64'(L + 2));
         check({tag, "_data"}, 64'(out_data), 64'(exp_d));
         check({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
      end
      @(negedge clk);
      check({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
      check({tag, "_busy_fall"}, 64'(busy), 64'd0);
      check({tag, "_data_hold"}, 64'(out_data), 64'(exp_d));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_mul_a"}, 64'(mul_a), 64'd0);
      check({tag, "_mul_b"}, 64'(mul_b), 64'd0);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"}, 64'(out_data), 64'd0);
      check({tag, "_sat"}, 64'(out_sat), 64'd0);
   endtask

   initial begin
      int seen;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      load_pairs(3, 32'h0001_0000, 32'h0002_0000);
      run_cmd(3, 32'h0006_0000, 1'b0, "basic");

      va[0] = 32'hFFFE_8000; vb[0] = 32'h0002_0000;
      va[1] = 32'h0000_0001; vb[1] = 32'h0000_0001;
      run_cmd(2, 32'hFFFD_0000, 1'b0, "signed");

      load_pairs(2, 32'h7FFF_0000, 32'h7FFF_0000);
      run_cmd(2, 32'h7FFF_FFFF, 1'b1, "sat_pos");

      load_pairs(2, 32'h8001_0000, 32'h7FFF_0000);
      run_cmd(2, 32'h8000_0000, 1'b1, "sat_neg");

      load_pairs(4, 32'h0001_0000, 32'h0001_0000);
      vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      run_cmd(4, 32'h0004_0000, 1'b0, "bubbles");
      vpat.delete();

      run_cmd(0, 32'h0000_0000, 1'b0, "len0");

      load_pairs(3, 32'h0001_0000, 32'h0002_0000);
      poke = 1'b1;
      run_cmd(3, 32'h0006_0000, 1'b0, "start_ignored");
      poke = 1'b0;

      // Reset while the second product is still in the multiplier.
      @(negedge clk);
      start = 1'b1;
      len   = LW'(2);
      @(negedge clk);
      start    = 1'b0;
      len      = '0;
      in_valid = 1'b1;
      in_a     = 32'h0001_0000;
      in_b     = 32'h0001_0000;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (L + 6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_reset_no_valid", 64'(seen), 64'd0);
      check("mid_reset_idle", 64'(busy), 64'd0);

      va[0] = 32'h0003_0000; vb[0] = 32'h0001_0000;
      run_cmd(1, 32'h0003_0000, 1'b0, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
